// File: rtl/fpio_arb_pkg.sv
// fpio_arb_pkg: state encoding and grant-index sizing shared by the FPIO TX arbiter.
package fpio_arb_pkg;
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;
    localparam int N_REQ_MAX = 8;
    localparam int GID_W_MAX = $clog2(N_REQ_MAX);
    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fpio_rr_sel.sv
// fpio_rr_sel: picks the first eligible requester at or after ptr, wrapping upward.
module fpio_rr_sel import fpio_arb_pkg::*; #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        elig,
    input  logic [gid_w(N_REQ)-1:0] ptr,
    output logic                    found,
    output logic [gid_w(N_REQ)-1:0] idx
);
    localparam int GW = gid_w(N_REQ);
    // The second pass overrides the first, so indices at/after ptr win over wrapped ones.
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (elig[j] && j < int'(ptr)) begin
                found = 1'b1;
                idx = GW'(j);
            end
        end
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (elig[j] && j >= int'(ptr)) begin
                found = 1'b1;
                idx = GW'(j);
            end
        end
    end
endmodule

// File: rtl/fpio_tx_arb.sv
// fpio_tx_arb: packet-locked round-robin merge of N_REQ beat streams into one
// registered output stream toward the FPIO output FIFO.
module fpio_tx_arb import fpio_arb_pkg::*; #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_REQ-1:0]            en_mask,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [gid_w(N_REQ)-1:0]     grant_id,
    output logic                        busy
);
    localparam int GW = gid_w(N_REQ);
    arb_state_t state, state_nxt;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] pick;
    logic found;
    logic take;
    logic take_last;
    logic [DATA_WIDTH-1:0] data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    fpio_rr_sel #(.N_REQ(N_REQ)) u_sel (
        .elig  (req_valid & en_mask),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick)
    );

    assign busy = (state == LOCKED);
    assign take = req_valid[grant_id] && req_ready[grant_id];
    assign take_last = take && req_last[grant_id];

    // Only the owner is ever ready, and only when the output register can take a beat.
    always_comb begin
        req_ready = '0;
        req_ready[grant_id] = busy && (!out_valid || out_ready);
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = found ? LOCKED : IDLE;
        else
            state_nxt = take_last ? IDLE : LOCKED;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (state == IDLE && found)
                grant_id <= pick;
            if (take_last)
                rr_ptr <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + GW'(1);
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= data_arr[grant_id];
                out_last  <= req_last[grant_id];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fpio_tx_arb.sv
// tb_fpio_tx_arb: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based behavioural model of the arbiter.
module tb_fpio_tx_arb;
    localparam int N = 4;
    localparam int DW = 32;
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [N-1:0] en_mask = '0;
    logic [N-1:0] req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] req_ready;
    logic out_valid;
    logic [DW-1:0] out_data;
    logic out_last;
    logic out_ready = 1'b0;
    logic [1:0] grant_id;
    logic busy;

    fpio_tx_arb #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en_mask   (en_mask),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    beat_t bq [N][$];
    beat_t oq [$];
    logic [DW-1:0] obs [$];
    logic [N-1:0] vld = '0;
    int vpct = 100;
    int rpct = 100;
    bit en_rand = 1'b0;
    bit locked;
    int owner, gid, ptr;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        locked = 1'b0;
        owner = 0;
        gid = 0;
        ptr = 0;
        oq.delete();
    endtask

    function automatic logic [N-1:0] exp_rdy();
        return (locked && (oq.size() == 0 || out_ready)) ? (N'(1) << owner) : '0;
    endfunction

    // Model: a packet owner, a one-deep output queue and a rotating start index.
    task automatic model_step(input logic [N-1:0] rdy);
        beat_t b;
        if (oq.size() != 0 && out_ready) oq.delete(0);
        if (locked) begin
            if (vld[owner] && rdy[owner]) begin
                b = bq[owner][0];
                oq.push_back(b);
                if (b.l) begin
                    locked = 1'b0;
                    ptr = (owner + 1) % N;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                automatic int j = (ptr + k) % N;
                if (!locked && vld[j] && en_mask[j]) begin
                    locked = 1'b1;
                    owner = j;
                    gid = j;
                end
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] er;
        @(negedge clk);
        out_ready = ($urandom_range(99) < rpct);
        if (en_rand && $urandom_range(19) == 0) en_mask = N'($urandom);
        for (int i = 0; i < N; i++) begin
            if (!vld[i] && bq[i].size() != 0 && $urandom_range(99) < vpct) vld[i] = 1'b1;
            req_data[i*DW +: DW] = (bq[i].size() != 0) ? bq[i][0].d : '0;
            req_last[i] = (bq[i].size() != 0) && bq[i][0].l;
        end
        req_valid = vld;
        if (!rstn) mreset();
        #1;
        er = exp_rdy();
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("busy", 64'(busy), 64'(locked));
        chk("grant_id", 64'(grant_id), 64'(gid));
        chk("out_valid", 64'(out_valid), 64'(oq.size() != 0));
        if (oq.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(oq[0].d));
            chk("out_last", 64'(out_last), 64'(oq[0].l));
        end
        if (out_valid && out_ready) obs.push_back(out_data);
        if (rstn) model_step(er);
        for (int i = 0; i < N; i++) begin
            if (vld[i] && req_ready[i]) begin
                bq[i].delete(0);
                vld[i] = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic edge_sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        bq[i].push_back(b);
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) bq[i].delete();
        vld = '0;
        req_valid = '0;
        obs.delete();
    endtask

    initial begin
        logic [DW-1:0] held;
        int n1, n3, nx, left;
        bit cleared;
        en_mask = '1;
        run(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        edge_sync();
        rstn = 1'b1;

        for (int p = 0; p < 3; p++)
            for (int i = 0; i < N; i++) push(i, DW'(i), 1'b1);
        run(32);
        chk("fair_count", 64'(obs.size()), 64'd12);
        for (int k = 0; k < 12 && k < obs.size(); k++) chk("fair_order", 64'(obs[k]), 64'(k % 4));
        obs.delete();

        push(2, 32'hA0, 1'b0);
        push(2, 32'hA1, 1'b0);
        push(2, 32'hA2, 1'b1);
        cycle();
        chk("sp_c0_ready", 64'(req_ready), 64'd0);
        cycle();
        chk("sp_c1_ready", 64'(req_ready), 64'h4);
        cycle();
        chk("sp_c2_valid", 64'(out_valid), 64'd1);
        chk("sp_c2_data", 64'(out_data), 64'hA0);
        chk("sp_c2_last", 64'(out_last), 64'd0);
        cycle();
        chk("sp_c3_data", 64'(out_data), 64'hA1);
        chk("sp_c3_last", 64'(out_last), 64'd0);
        cycle();
        chk("sp_c4_data", 64'(out_data), 64'hA2);
        chk("sp_c4_last", 64'(out_last), 64'd1);
        chk("sp_grant", 64'(grant_id), 64'd2);
        cycle();
        chk("sp_c5_valid", 64'(out_valid), 64'd0);
        obs.delete();

        for (int k = 0; k < 8; k++) push(0, 32'hB0 + DW'(k), k == 7);
        for (int t = 0; t < 20 && obs.size() < 2; t++) cycle();
        chk("bp_start", 64'(obs.size() >= 2), 64'd1);
        rpct = 0;
        held = (oq.size() != 0) ? oq[0].d : '0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold", 64'(out_data), 64'(held));
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_stall", 64'(req_ready), 64'd0);
        end
        rpct = 100;
        run(20);
        chk("bp_count", 64'(obs.size()), 64'd8);
        for (int k = 0; k < 8 && k < obs.size(); k++) chk("bp_seq", 64'(obs[k]), 64'(32'hB0 + k));

        edge_sync();
        flush();
        en_mask = 4'b1010;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < N; i++) begin
                push(i, DW'(i * 16), 1'b0);
                push(i, DW'(i * 16 + 1), 1'b1);
            end
        cleared = 1'b0;
        for (int t = 0; t < 60; t++) begin
            cycle();
            if (!cleared && locked && owner == 1) begin
                edge_sync();
                en_mask[1] = 1'b0;
                cleared = 1'b1;
            end
        end
        n1 = 0;
        n3 = 0;
        nx = 0;
        foreach (obs[k]) begin
            if (obs[k][31:4] == 28'd1) n1++;
            else if (obs[k][31:4] == 28'd3) n3++;
            else nx++;
        end
        chk("mask_cleared", 64'(cleared), 64'd1);
        chk("mask_r1_beats", 64'(n1), 64'd2);
        chk("mask_r3_beats", 64'(n3), 64'd6);
        chk("mask_other", 64'(nx), 64'd0);
        chk("mask_idle", 64'(busy), 64'd0);
        edge_sync();
        flush();
        en_mask = '1;

        push(1, 32'hD0, 1'b1);
        run(6);
        obs.delete();
        for (int k = 0; k < 4; k++) push(2, 32'hC0 + DW'(k), k == 3);
        for (int t = 0; t < 20 && bq[2].size() > 2; t++) cycle();
        chk("rst_mid_reach", 64'(bq[2].size()), 64'd2);
        edge_sync();
        rstn = 1'b0;
        flush();
        cycle();
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'd0);
        edge_sync();
        rstn = 1'b1;
        for (int i = 0; i < N; i++) push(i, 32'hE0 + DW'(i), 1'b1);
        run(2);
        chk("rst_next_busy", 64'(busy), 64'd1);
        chk("rst_next_grant", 64'(grant_id), 64'd0);
        run(12);
        chk("rst_next_count", 64'(obs.size()), 64'd4);
        if (obs.size() != 0) chk("rst_next_first", 64'(obs[0]), 64'hE0);

        en_rand = 1'b1;
        rpct = 60;
        vpct = 70;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bq[i].size() < 2) begin
                    automatic int len = $urandom_range(4, 1);
                    for (int k = 0; k < len; k++) push(i, $urandom, k == len - 1);
                end
            end
            cycle();
        end
        en_rand = 1'b0;
        edge_sync();
        en_mask = '1;
        rpct = 100;
        vpct = 100;
        run(120);
        left = 0;
        for (int i = 0; i < N; i++) left += bq[i].size();
        chk("drain_left", 64'(left), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpio_tx_arb.md
FPIO_TX_ARB -- requirements
Module: fpio_tx_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (legal range 2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width of each beat.
REQ-003 clk  input  1  The block's single clock; all state changes on its rising edge.
REQ-004 rstn  input  1  Reset; asynchronous assertion, active-low.
REQ-005 en_mask  input  N_REQ  Per-requester enable; a requester with bit 0 is never newly granted.
REQ-006 req_valid  input  N_REQ  Per-requester beat valid.
REQ-007 req_data  input  N_REQ*DATA_WIDTH  Per-requester beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  N_REQ  Per-requester end-of-packet marker for the current beat.
REQ-009 req_ready  output  N_REQ  Per-requester beat accept.
REQ-010 out_valid  output  1  Merged stream valid toward the FPIO output FIFO.
REQ-011 out_data  output  DATA_WIDTH  Merged stream data.
REQ-012 out_last  output  1  Merged stream end-of-packet.
REQ-013 out_ready  input  1  Merged stream accept (FIFO not full).
REQ-014 grant_id  output  $clog2(N_REQ)  Index of the currently or most recently granted requester.
REQ-015 busy  output  1  High while a packet is locked to a requester.

Function
REQ-016 A transfer on any port SHALL occur only in a cycle where valid and ready are both high.
REQ-017 The state machine SHALL have two states: IDLE and LOCKED.
REQ-018 In IDLE, when any requester has req_valid and en_mask high, the block SHALL pick the first such index at or after rr_ptr, searching upward with wrap, then register grant_id and enter LOCKED on the next edge.
REQ-019 In IDLE, all req_ready bits SHALL be 0; with no eligible requester the block SHALL stay in IDLE.
REQ-020 In LOCKED, only req_ready[grant_id] SHALL be high, and it SHALL be high exactly when (!out_valid || out_ready).
REQ-021 The output SHALL be a single register stage: an accepted beat loads out_data and out_last and sets out_valid at the next edge.
REQ-022 out_valid SHALL clear after an out_ready handshake unless a new beat is loaded in the same cycle.
REQ-023 out_data and out_last SHALL remain stable while out_valid && !out_ready.
REQ-024 Acceptance of a beat with req_last high SHALL return the block to IDLE and set rr_ptr = (grant_id+1) mod N_REQ.
REQ-025 Latency SHALL be: req_valid in IDLE at cycle 0 -> req_ready at cycle 1 -> out_valid at cycle 2 (with out_ready held high).
REQ-026 Between packets the block SHALL insert exactly one IDLE cycle with no req_ready.
REQ-027 Deassertion of en_mask[grant_id] mid-packet SHALL be ignored until the last beat (packet integrity).
REQ-028 A req_valid low gap mid-packet SHALL keep the block in LOCKED with grant unchanged.
REQ-029 With out_ready low, the block SHALL hold exactly one beat in the output register and stall the granted requester.
REQ-030 busy SHALL equal (state == LOCKED).

Reset
REQ-031 On rstn low, the block SHALL asynchronously set: state IDLE, rr_ptr 0, grant_id 0, out_valid 0, out_data 0, out_last 0, req_ready all 0, busy 0.
REQ-032 Reset asserted mid-packet SHALL discard the packet and any held output beat, and SHALL require no recovery sequence.

Structure
REQ-033 The state enum (IDLE, LOCKED) and the localparam for grant-index width SHALL be placed in package fpio_arb_pkg.
REQ-034 The round-robin search SHALL be a combinational sub-module, fpio_rr_sel (inputs: eligible mask and rr_ptr; outputs: found and index), instantiated once.

Verification
REQ-035 Single packet: requester 2 sends 3 beats (0xA0, 0xA1, 0xA2 with last), out_ready=1 -> out_data 0xA0/0xA1/0xA2 on consecutive cycles starting cycle 2, out_last only on 0xA2, grant_id=2.
REQ-036 Fairness: all 4 requesters continuously send 1-beat packets -> grant order 0,1,2,3,0 with one bubble between packets.
REQ-037 Backpressure: out_ready low for 5 cycles mid-packet -> out_data held constant, req_ready low for the granted requester, no beat lost or duplicated.
REQ-038 Mask: en_mask=4'b1010 with all requesters valid -> only 1 and 3 granted; clearing en_mask[1] mid-packet still completes that packet.
REQ-039 Reset mid-packet: rstn pulsed low during beat 2 of 4 -> out_valid=0, busy=0, and the next grant comes from rr_ptr 0.
